result_serializer: RTL

//  Output-side counterpart of the TPU load path: captures the four 2x2 systolic-array results

---
 rtl/result_serializer_pkg.sv | 16 +
 rtl/result_serializer_frame_reg.sv | 47 ++++
 rtl/result_serializer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg
//   Shared definitions for the result serializer: default widths, frame
//   geometry and the FSM state encoding.
//   Ports: none (package).
package result_serializer_pkg;

    localparam int DATA_W_DEF = 16;  // accumulator width per result
    localparam int OUT_W_DEF  = 8;   // output byte-lane width
    localparam int NUM_WORDS  = 4;   // c00, c01, c10, c11

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_serializer_frame_reg.sv
// result_serializer_frame_reg
//   Shadow register holding the frame currently being transmitted, with a
//   byte-select read mux. The frame is packed {c11, c10, c01, c00}, so byte k
//   of the transmit order lives at bits [k*OUT_W +: OUT_W] (LS byte of c00
//   first).
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     load        : replace the shadow contents with load_frame
//     load_frame  : packed frame to load
//     byte_idx    : byte to present on byte_out
//     byte_out    : selected byte of the held frame
module result_serializer_frame_reg
    import result_serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int IDX_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [NUM_WORDS*DATA_W-1:0]   load_frame,
    input  logic [IDX_W-1:0]              byte_idx,
    output logic [OUT_W-1:0]              byte_out
);

    logic [NUM_WORDS*DATA_W-1:0] frame_q;
    logic [NUM_WORDS*DATA_W-1:0] frame_d;

    always_comb begin
        frame_d = frame_q;
        if (load) begin
            frame_d = load_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign byte_out = frame_q[int'(byte_idx) * OUT_W +: OUT_W];

endmodule

// File: rtl/result_serializer.sv
// result_serializer
//   Captures the four 2x2 systolic-array results on a capture strobe and
//   streams them to the host as bytes: c00, c01, c10, c11, each LS byte first.
//   One frame is held in transmission (shadow register) and one more can wait
//   in a pending buffer, so back-to-back frames stream without idle cycles.
//
//   Handshake: a byte transfers on any rising edge where out_valid and
//   out_ready are both high. Once out_valid rises it stays high, and out_data
//   and out_last stay stable, until that transfer happens (or enable/rst_n
//   abort the frame).
//
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     enable              : low aborts the current frame and flushes pending
//     capture             : 1-cycle strobe, c00..c11 hold a finished frame
//     c00, c01, c10, c11  : array results
//     out_ready           : host accepts out_data this cycle
//     clr_ovr             : clears the sticky overrun flag
//     out_data            : current byte (0 when not valid)
//     out_valid           : out_data valid
//     out_last            : final byte of frame
//     busy                : frame in flight or pending
//     overrun             : sticky, a capture was dropped
//     dbg_state           : current FSM state
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              capture,
    input  logic [DATA_W-1:0] c00,
    input  logic [DATA_W-1:0] c01,
    input  logic [DATA_W-1:0] c10,
    input  logic [DATA_W-1:0] c11,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    output state_t            dbg_state
);

    localparam int BPW   = DATA_W / OUT_W;
    localparam int N     = NUM_WORDS * BPW;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int FW    = NUM_WORDS * DATA_W;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   byte_idx_q,   byte_idx_d;
    logic [FW-1:0]      pend_q,       pend_d;
    logic               pend_full_q,  pend_full_d;
    logic               overrun_q,    overrun_d;

    logic               load;
    logic [FW-1:0]      load_frame;
    logic [FW-1:0]      in_frame;
    logic [OUT_W-1:0]   frame_byte;
    logic               send;
    logic               hs;
    logic               at_last;

    assign in_frame = {c11, c10, c01, c00};
    assign send     = (state_q == ST_SEND);
    assign at_last  = (byte_idx_q == IDX_W'(N - 1));
    assign hs       = send & out_ready;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        // Clear first so a same-cycle drop below wins over clr_ovr.
        overrun_d   = clr_ovr ? 1'b0 : overrun_q;
        load        = 1'b0;
        load_frame  = in_frame;

        if (!enable) begin
            // Abort: partial frame abandoned, pending flushed, overrun kept.
            state_d     = ST_IDLE;
            byte_idx_d  = '0;
            pend_full_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Pending is always empty here, so capture goes straight
                    // to the shadow register.
                    if (capture) begin
                        load       = 1'b1;
                        byte_idx_d = '0;
                        state_d    = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs && at_last) begin
                        byte_idx_d = '0;
                        if (pend_full_q) begin
                            // Promote pending; a coincident capture refills it.
                            load        = 1'b1;
                            load_frame  = pend_q;
                            if (capture) begin
                                pend_d = in_frame;
                            end else begin
                                pend_full_d = 1'b0;
                            end
                        end else if (capture) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        if (hs) begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                        if (capture) begin
                            if (!pend_full_q) begin
                                pend_d      = in_frame;
                                pend_full_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
        end
    end

    result_serializer_frame_reg #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .IDX_W  (IDX_W)
    ) u_frame_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_frame (load_frame),
        .byte_idx   (byte_idx_q),
        .byte_out   (frame_byte)
    );

    // Outputs decode directly from flops, so they change only at clock edges.
    assign out_valid = send;
    assign out_data  = send ? frame_byte : '0;
    assign out_last  = send & at_last;
    assign busy      = send | pend_full_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule
